// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: loader FSM encoding
// and the word/byte widths also used by the IMEM and PC modules.
package imem_loader_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Collects four bytes, most significant byte first, into one 32-bit word.
// word_full_o flags the accept that completes the word.
module imem_loader_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              accept_i,
  input  logic              clear_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_full_o
);

  logic [1:0]        idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;

  // The index wraps to 0 after byte 3, so the next word starts without a bubble.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d = 2'd0;
    end else if (accept_i) begin
      idx_d = idx_q + 2'd1;
      case (idx_q)
        2'd0:    word_d[31:24] = byte_i;
        2'd1:    word_d[23:16] = byte_i;
        2'd2:    word_d[15:8]  = byte_i;
        default: word_d[7:0]   = byte_i;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= 2'd0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = accept_i && (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Program loader: assembles a byte stream into instructions, writes them to
// consecutive IMEM words and holds the CPU in reset until the load completes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic [WORD_W-1:0] checksum
);

  localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0] csum_q, csum_d;
  logic              hold_q, hold_d;

  logic [ADDR_W:0]   clampedCount;
  logic              asmAccept;
  logic              asmClear;
  logic              wordFull;
  logic [WORD_W-1:0] asmWord;

  assign clampedCount = (word_count > DEPTH_W) ? DEPTH_W : word_count;
  assign in_ready     = (state_q == RECV);
  assign asmAccept    = in_valid && in_ready;
  // A fresh start or an abort drops any partially assembled word.
  assign asmClear     = ((state_q == IDLE) && start && !abort) ||
                        (abort && ((state_q == RECV) || (state_q == WRITE)));

  imem_loader_byte_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .accept_i   (asmAccept),
    .clear_i    (asmClear),
    .byte_i     (in_data),
    .word_o     (asmWord),
    .word_full_o(wordFull)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    hold_d  = hold_q;
    wr_en   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          base_d  = base_addr;
          count_d = clampedCount;
          cnt_d   = '0;
          csum_d  = '0;
          hold_d  = 1'b1;
          state_d = (clampedCount == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (abort) begin
          state_d = IDLE;
        end else if (wordFull) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        // The write completes even when an abort lands on this cycle.
        wr_en  = 1'b1;
        csum_d = csum_q + asmWord;
        cnt_d  = cnt_q + 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_d == count_q) begin
          state_d = DONE;
        end else begin
          state_d = RECV;
        end
      end
      DONE: begin
        done    = 1'b1;
        hold_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      count_q <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      hold_q  <= hold_d;
    end
  end

  // Release the CPU in the same cycle as the done pulse.
  assign cpu_hold = hold_q && (state_q != DONE);
  assign busy     = (state_q != IDLE);
  assign wr_addr  = base_q + cnt_q[ADDR_W-1:0];
  assign wr_data  = asmWord;
  assign checksum = csum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected IMEM writes,
// a negedge monitor pops and compares them whenever wr_en is seen.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  word_count = '0;
  logic [7:0]  in_data = '0;
  logic        in_ready, wr_en, busy, done, cpu_hold;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data, checksum;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         expQ[$];
  wr_t         popped;
  logic [31:0] wordBuf [0:255];
  int          passCount = 0;
  int          totalCount = 0;
  int          doneSeen = 0;
  int          doneExp = 0;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .cpu_hold  (cpu_hold),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (done) doneSeen++;
      if (wr_en) begin
        if (expQ.size() == 0) begin
          check("unexpected write (addr shown)", {24'b0, wr_addr}, 32'hFFFF_FFFF);
        end else begin
          popped = expQ.pop_front();
          check("wr_addr", {24'b0, wr_addr}, {24'b0, popped.addr});
          check("wr_data", wr_data, popped.data);
          check("in_ready during write", 32'(in_ready), 32'd0);
        end
      end
    end
  end

  task automatic checkResetValues(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " in_ready"}, 32'(in_ready), 32'd0);
    check({tag, " wr_en"}, 32'(wr_en), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " wr_addr"}, {24'b0, wr_addr}, 32'd0);
    check({tag, " wr_data"}, wr_data, 32'd0);
    check({tag, " checksum"}, checksum, 32'd0);
    check({tag, " cpu_hold"}, 32'(cpu_hold), 32'd1);
  endtask

  task automatic doStart(input logic [7:0] b, input logic [8:0] c);
    start = 1'b1;
    base_addr = b;
    word_count = c;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data = b;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    check("byte accepted", 32'(ok), 32'd1);
  endtask

  task automatic sendWord(input logic [31:0] w, input int maxGap);
    for (int k = 0; k < 4; k++) begin
      sendByte(w[31-8*k -: 8], (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
    end
  endtask

  task automatic waitDone(input string name, input int expLat);
    int lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
    check({name, " done seen"}, 32'(lat != 0), 32'd1);
    if (expLat > 0) check({name, " done latency"}, 32'(lat), 32'(expLat));
  endtask

  task automatic runLoad(input string name, input logic [7:0] base, input logic [8:0] cnt,
                         input int nWords, input int maxGap, input int expLat);
    logic [31:0] sum = '0;
    for (int i = 0; i < nWords; i++) begin
      expQ.push_back('{addr: base + 8'(i), data: wordBuf[i]});
      sum += wordBuf[i];
    end
    doStart(base, cnt);
    if (nWords > 0) begin
      check({name, " busy after start"}, 32'(busy), 32'd1);
      check({name, " cpu_hold during load"}, 32'(cpu_hold), 32'd1);
    end
    for (int i = 0; i < nWords; i++) sendWord(wordBuf[i], maxGap);
    in_valid = 1'b0;
    waitDone(name, expLat);
    doneExp++;
    check({name, " cpu_hold at done"}, 32'(cpu_hold), 32'd0);
    check({name, " checksum"}, checksum, sum);
    @(posedge clk);
    #1;
    check({name, " idle after done"}, 32'(busy), 32'd0);
    check({name, " cpu_hold after done"}, 32'(cpu_hold), 32'd0);
    if (busy) begin
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
    end
  endtask

  initial begin
    #2 reset = 1'b0;
    #1 checkResetValues("reset");
    #19 reset = 1'b1;
    @(posedge clk);
    #1;

    wordBuf[0] = 32'h014B_4820;
    runLoad("single", 8'd0, 9'd1, 1, 0, 2);

    wordBuf[0] = 32'h1122_3344;
    wordBuf[1] = 32'hDEAD_BEEF;
    wordBuf[2] = 32'h0A0B_0C0D;
    runLoad("backpressure", 8'd4, 9'd3, 3, 3, 0);

    wordBuf[0] = 32'hCAFE_F00D;
    wordBuf[1] = 32'h1234_5678;
    runLoad("wrap", 8'd255, 9'd2, 2, 1, 0);

    expQ.push_back('{addr: 8'd16, data: 32'h0102_0304});
    doStart(8'd16, 9'd2);
    sendWord(32'h0102_0304, 0);
    sendByte(8'hAA, 0);
    sendByte(8'hBB, 0);
    in_valid = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort idle", 32'(busy), 32'd0);
    check("abort cpu_hold", 32'(cpu_hold), 32'd1);
    check("abort checksum held", checksum, 32'h0102_0304);
    check("abort no done", 32'(doneSeen), 32'(doneExp));
    check("abort first word written", 32'(expQ.size()), 32'd0);
    @(posedge clk);
    #1;
    wordBuf[0] = 32'h5566_7788;
    runLoad("after abort", 8'd16, 9'd1, 1, 0, 0);

    start = 1'b1;
    abort = 1'b1;
    base_addr = 8'd3;
    word_count = 9'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("start+abort ignored", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    if (busy) begin
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
    end

    runLoad("zero count", 8'd7, 9'd0, 0, 0, 1);

    for (int i = 0; i < 256; i++) wordBuf[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'h3C};
    runLoad("clamp", 8'h80, 9'h1FF, 256, 0, 0);

    expQ.push_back('{addr: 8'd32, data: 32'h0F1E_2D3C});
    doStart(8'd32, 9'd1);
    sendByte(8'h0F, 0);
    in_valid = 1'b0;
    start = 1'b1;
    base_addr = 8'd99;
    word_count = 9'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start ignored busy", 32'(busy), 32'd1);
    sendByte(8'h1E, 0);
    sendByte(8'h2D, 0);
    sendByte(8'h3C, 0);
    in_valid = 1'b0;
    waitDone("start ignored", 0);
    doneExp++;
    check("start ignored checksum", checksum, 32'h0F1E_2D3C);
    @(posedge clk);
    #1;

    expQ.push_back('{addr: 8'd40, data: 32'h1357_9BDF});
    doStart(8'd40, 9'd2);
    sendWord(32'h1357_9BDF, 0);
    sendByte(8'h24, 0);
    sendByte(8'h68, 0);
    in_valid = 1'b0;
    check("pre-reset checksum", checksum, 32'h1357_9BDF);
    #2 reset = 1'b0;
    #1 checkResetValues("async reset");
    #10 reset = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset idle", 32'(busy), 32'd0);
    check("post-reset cpu_hold", 32'(cpu_hold), 32'd1);

    check("done pulse count", 32'(doneSeen), 32'(doneExp));
    check("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
